// File: rtl/judge_pkg.sv
// Shared types and constants for the reaction-round judge: FSM encoding,
// LFSR geometry and the delay counter width.
package judge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_LIT    = 3'd2,
    ST_RESULT = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam int LFSR_W = 8;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3 of the shift register
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
  localparam int CNT_W = 24;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/judge_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; a nonzero seed keeps it on the
// maximal-length cycle so it never reaches zero.
module judge_lfsr
  import judge_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] value
);

  // Advance one step every cycle, independent of the round state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= {value[LFSR_W-2:0], lfsr_feedback(value)};
    end
  end

endmodule

// File: rtl/round_judge.sv
// Reaction-game round judge: random delay, lights, first-push decision.
// Optional LIT timeout enabled by defining ROUND_JUDGE_TIMEOUT_EN.
module round_judge
  import judge_pkg::*;
#(
  parameter int               DELAY_MIN   = 1000,
  parameter int               DELAY_SHIFT = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5,
  parameter int               TIMEOUT     = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_l,
  input  logic pb_r,
  input  logic game_over,
  output logic leds_on,
  output logic winrnd,
  output logic right,
  output logic tie
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, load_val;
  logic [LFSR_W-1:0] lfsr;
  logic              pb_l_d, pb_r_d, push_l, push_r;
  logic              leds_next, winrnd_next, right_next, tie_next;

  // The delay counter doubles as the LIT timeout counter; that value is only
  // consulted when the timeout is built in.
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

  judge_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  assign push_l   = pb_l & ~pb_l_d;
  assign push_r   = pb_r & ~pb_r_d;
  assign load_val = CNT_W'(DELAY_MIN) + (CNT_W'(lfsr) << DELAY_SHIFT);

  // Next-state and next-output decode; outputs are registered from these
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    leds_next   = 1'b0;
    winrnd_next = 1'b0;
    right_next  = right;
    tie_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!game_over && !pb_l && !pb_r) begin
          state_next = ST_DELAY;
          cnt_next   = load_val;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (game_over) begin
          state_next = ST_HOLD;
        end else if (push_l && push_r) begin
          state_next = ST_HOLD;
          tie_next   = 1'b1;
        end else if (push_l || push_r) begin
          state_next  = ST_RESULT;
          winrnd_next = 1'b1;
          right_next  = push_r;
        end else if (cnt <= 24'd1) begin
          state_next = ST_LIT;
          leds_next  = 1'b1;
          cnt_next   = TIMEOUT_LOAD;
        end else begin
          cnt_next = cnt - 24'd1;
        end
      end
      ST_LIT: begin
        if (game_over) begin
          state_next = ST_HOLD;
        end else if (push_l && push_r) begin
          state_next = ST_HOLD;
          tie_next   = 1'b1;
        end else if (push_l || push_r) begin
          state_next  = ST_RESULT;
          winrnd_next = 1'b1;
          right_next  = push_r;
          leds_next   = 1'b1;
`ifdef ROUND_JUDGE_TIMEOUT_EN
        end else if (cnt == 24'd0) begin
          state_next = ST_HOLD;
          tie_next   = 1'b1;
        end else begin
          leds_next = 1'b1;
          cnt_next  = cnt - 24'd1;
        end
`else
        end else begin
          leds_next = 1'b1;
        end
`endif
      end
      ST_RESULT: begin
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!pb_l && !pb_r) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_HOLD;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter, edge-detect history and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= {CNT_W{1'b0}};
      pb_l_d  <= 1'b1;
      pb_r_d  <= 1'b1;
      leds_on <= 1'b0;
      winrnd  <= 1'b0;
      right   <= 1'b0;
      tie     <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pb_l_d  <= pb_l;
      pb_r_d  <= pb_r;
      leds_on <= leds_next;
      winrnd  <= winrnd_next;
      right   <= right_next;
      tie     <= tie_next;
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: expected pulses are queued as pushes are
// driven and compared by a monitor when winrnd/tie appear.
module tb_round_judge;

  localparam int         DMIN = 4;
  localparam logic [7:0] SEED = 8'h03;
  localparam int         TOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_l = 1'b0;
  logic pb_r = 1'b0;
  logic game_over = 1'b0;
  logic leds_on, winrnd, right, tie;

  int checks = 0;
  int failures = 0;

  // {tie, right, leds_on} expected for each pulse
  logic [2:0] exp_q[$];
  logic [7:0] m_lfsr;

  round_judge #(
    .DELAY_MIN   (DMIN),
    .DELAY_SHIFT (0),
    .LFSR_SEED   (SEED),
    .TIMEOUT     (TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_l      (pb_l),
    .pb_r      (pb_r),
    .game_over (game_over),
    .leds_on   (leds_on),
    .winrnd    (winrnd),
    .right     (right),
    .tie       (tie)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 8,6,5,4, shifting toward the MSB
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Pulse monitor: every winrnd/tie must match the head of the queue
  initial begin : monitor
    logic       prev_win;
    logic [2:0] e;
    prev_win = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (winrnd || tie)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got winrnd=%0b tie=%0b right=%0b leds_on=%0b, required no pulse",
                   winrnd, tie, right, leds_on);
        end else begin
          e = exp_q.pop_front();
          if (winrnd !== ~e[2] || tie !== e[2] || leds_on !== e[0] || (!e[2] && right !== e[1])) begin
            failures++;
            $display("FAIL pulse_mismatch: got winrnd=%0b tie=%0b right=%0b leds_on=%0b, required tie=%0b right=%0b leds_on=%0b",
                     winrnd, tie, right, leds_on, e[2], e[1], e[0]);
          end
        end
      end
      if (!rst && winrnd) begin
        checks++;
        if (prev_win) begin
          failures++;
          $display("FAIL winrnd_consecutive: got two winrnd cycles, required one");
        end
      end
      prev_win = winrnd;
    end
  end

  task automatic do_reset(input logic l, input logic r);
    @(negedge clk);
    rst = 1'b1; pb_l = l; pb_r = r; game_over = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Call at a falling edge where the DUT is in IDLE with inputs low
  task automatic wait_rise(input string name);
    int exp_k, k;
    exp_k = DMIN + int'(m_lfsr) + 1;
    k = 0;
    for (int i = 1; i <= 400 && k == 0; i++) begin
      @(negedge clk);
      if (leds_on === 1'b1) k = i;
    end
    checks++;
    if (k !== exp_k) begin
      failures++;
      $display("FAIL %s: leds_on rose after %0d cycles, required %0d", name, k, exp_k);
    end
  endtask

  task automatic quiet_for(input string name, input int n, input logic allow_leds);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (winrnd !== 1'b0 || tie !== 1'b0 || (!allow_leds && leds_on !== 1'b0)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s: got %0d cycles with activity, required 0", name, bad);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({leds_on, winrnd, right, tie} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 0000", {leds_on, winrnd, right, tie});
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b0, 1'b0);
    wait_rise("first_delay");
    exp_q.push_back(3'b011);
    pb_r = 1'b1;
    @(negedge clk);
    checks++;
    if (winrnd !== 1'b1) begin
      failures++;
      $display("FAIL lit_latency: got winrnd=%0b, required 1", winrnd);
    end
    @(negedge clk);
    checks++;
    if ({winrnd, leds_on} !== 2'b00) begin
      failures++;
      $display("FAIL hold_after_result: got winrnd,leds_on=%b, required 00", {winrnd, leds_on});
    end
    pb_r = 1'b0;
    @(negedge clk);
    wait_rise("second_delay");
    exp_q.push_back(3'b001);
    pb_l = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pb_l = 1'b0;
  endtask

  task automatic test_jump;
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(3'b000);
    pb_l = 1'b1;
    @(negedge clk);
    checks++;
    if (winrnd !== 1'b1 || right !== 1'b0 || leds_on !== 1'b0) begin
      failures++;
      $display("FAIL jump_result: got winrnd=%0b right=%0b leds_on=%0b, required 1 0 0", winrnd, right, leds_on);
    end
    quiet_for("jump_no_lights", 20, 1'b0);
    pb_l = 1'b0;
  endtask

  task automatic test_tie;
    do_reset(1'b0, 1'b0);
    wait_rise("tie_delay");
    exp_q.push_back(3'b100);
    pb_l = 1'b1; pb_r = 1'b1;
    @(negedge clk);
    checks++;
    if (tie !== 1'b1 || winrnd !== 1'b0) begin
      failures++;
      $display("FAIL tie_pulse: got tie=%0b winrnd=%0b, required 1 0", tie, winrnd);
    end
    quiet_for("tie_hold_both", 5, 1'b0);
    pb_l = 1'b0;
    quiet_for("tie_hold_one", 5, 1'b0);
    pb_r = 1'b0;
    @(negedge clk);
    wait_rise("tie_release_restart");
  endtask

  task automatic test_held_through_reset;
    do_reset(1'b0, 1'b1);
    quiet_for("held_reset_idle", 10, 1'b0);
    pb_r = 1'b0;
    wait_rise("held_reset_restart");
  endtask

  task automatic test_game_over;
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    game_over = 1'b1;
    quiet_for("game_over_frozen", 300, 1'b0);
    game_over = 1'b0;
    wait_rise("game_over_restart");
  endtask

  task automatic test_reset_mid_round;
    do_reset(1'b0, 1'b0);
    wait_rise("mid_round_delay");
    rst = 1'b1; pb_r = 1'b1;
    #1;
    checks++;
    if ({leds_on, winrnd, right, tie} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: got %b, required 0000", {leds_on, winrnd, right, tie});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_for("mid_round_discard", 5, 1'b0);
    pb_r = 1'b0;
    wait_rise("mid_round_restart");
  endtask

  task automatic test_timeout;
    int k;
    do_reset(1'b0, 1'b0);
    wait_rise("timeout_delay");
`ifdef ROUND_JUDGE_TIMEOUT_EN
    exp_q.push_back(3'b100);
    k = 0;
    for (int i = 1; i <= 50 && k == 0; i++) begin
      @(negedge clk);
      if (tie === 1'b1) k = i;
    end
    checks++;
    if (k !== TOUT || leds_on !== 1'b0) begin
      failures++;
      $display("FAIL timeout_tie: got tie after %0d cycles leds_on=%0b, required %0d and 0", k, leds_on, TOUT);
    end
`else
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (leds_on !== 1'b1) k++;
    end
    checks++;
    if (k !== 0) begin
      failures++;
      $display("FAIL lit_wait: got %0d dark cycles, required 0", k);
    end
`endif
    do_reset(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_jump();
    test_tie();
    test_held_through_reset();
    test_game_over();
    test_reset_mid_round();
    test_timeout();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d unmatched expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
